mdio_clock_gen: RTL and testbench
=================================

Name: mdio_clock_gen

Overview:
- Parametrised MDC generator for the Ethernet MAC SMI/MDIO management path, successor to the fixed 100 MHz / 1 MHz enable generator.
- Produces a registered MDC clock plus single-cycle rise/fall strobes in the clk domain. The MDIO shift FSM uses these strobes to drive MDIO after falling edges and to sample it at rising edges.
- Divider is runtime-programmable; the clock is started and stopped cleanly with an enable.

Parameters:
- DIV_WIDTH, 8, width of the half-period divider and of half_period.
- DEFAULT_HALF_PERIOD, 50, half-period in clk cycles after reset (100 MHz clk -> 1 MHz MDC).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- half_period  in  DIV_WIDTH  new half-period value, in clk cycles.
- half_period_load  in  1  one-cycle strobe; captures half_period.
- mdc  out  1  registered MDC clock output.
- mdc_rise_en  out  1  one-cycle strobe in the clk cycle before mdc goes 0->1.
- mdc_fall_en  out  1  one-cycle strobe in the clk cycle before mdc goes 1->0.
- active  out  1  high while state != IDLE.

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is synchronous and active-high.
- Reset values: state=IDLE, mdc=0, mdc_rise_en=0, mdc_fall_en=0, active=0, counter=1, hp_cur=hp_pend=DEFAULT_HALF_PERIOD.
- Reset mid-period: MDC is forced low on the next clk edge. No strobe is emitted.
- Divider values: load values 0 and 1 are clamped to 2 (MIN_HALF_PERIOD). Arithmetic is unsigned DIV_WIDTH. The counter never exceeds hp_cur, so there is no wrap.
- Loading:
  - half_period_load writes hp_pend.
  - hp_pend is copied to hp_cur in IDLE, or on any half-period boundary (counter==hp_cur in LOW or HIGH).
  - A load in the same cycle as a boundary takes effect for the next half-period.
  - A load in IDLE applies before the first LOW period.
- FSM states: IDLE, LOW, HIGH.
  - IDLE: mdc=0, counter=1. When enable=1 -> LOW on the next cycle.
  - LOW: mdc=0; counter increments each cycle.
    - enable=0 -> IDLE immediately, no strobe.
    - Else when counter==hp_cur: mdc_rise_en=1 (combinational), counter<=1, -> HIGH.
  - HIGH: mdc=1; counter increments each cycle. A high phase always completes, even if enable drops.
    - When counter==hp_cur: mdc_fall_en=1, counter<=1, -> LOW if enable else IDLE.
- Strobe rules:
  - Strobes are never simultaneous, and each lasts exactly one cycle.
  - mdc updates on the clk edge after its strobe.
- Latency: enable rises at cycle 0 -> LOW from cycle 1 -> mdc_rise_en at cycle hp_cur -> mdc=1 at cycle hp_cur+1.
- MDC timing: period = 2*hp_cur clk cycles, 50% duty. MDC never produces a runt pulse.

Optional Feature:
- Macro: MDIO_CLOCK_BURST_EN.
- With the macro:
  - Extra ports: burst_len in 7 (cycle count, 0 treated as 1), burst_start in 1 (strobe), burst_done out 1 (one-cycle pulse).
  - burst_start in IDLE loads the remaining-cycle counter and runs exactly burst_len full MDC cycles (e.g. 32 for the preamble) regardless of enable.
  - After the final fall: burst_done=1 in the same cycle as mdc_fall_en, then -> IDLE.
  - burst_start while active is ignored. Reset clears the burst counter; burst_done resets to 0.
- Without the macro: those ports are absent, and run/stop is controlled by enable only.

Decomposition:
- Shared package mdio_pkg holds:
  - mdio_clk_state_t enum {IDLE, LOW, HIGH}
  - MIN_HALF_PERIOD=2
  - MDIO_BURST_W=7
- No sub-module: the divider counter and FSM are small enough to stay inline.

Test Plan:
- Reset, then enable=1 with default hp=50 -> first mdc_rise_en at cycle 50 after enable; period 100 clk; rise/fall strobes alternate, one cycle each, 50 cycles apart.
- In IDLE, load half_period=5, then enable -> mdc period 10 clk. Load 0 -> period 4 (clamped to 2).
- While running at hp=10, load hp=3 mid-LOW -> the current half-period finishes at 10, and every later half-period is 3.
- Deassert enable mid-HIGH -> HIGH finishes, mdc_fall_en fires, IDLE, mdc=0. Deassert mid-LOW -> IDLE next cycle with no strobe.
- Assert reset mid-HIGH -> mdc=0, active=0, no strobes on the next edge. hp_cur returns to 50.
- MDIO_CLOCK_BURST_EN: burst_len=32, hp=2 -> exactly 32 rise strobes and 32 fall strobes, burst_done coincident with the 32nd fall, active low afterwards. burst_start during the burst is ignored.

Source files
------------

// File: rtl/mdio_clock_gen_pkg.sv
// Shared types and constants for the MDC clock generator.
// Used by mdio_clock_gen and mdio_clock_gen_if.
package mdio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } mdio_clk_state_t;

  localparam int MIN_HALF_PERIOD = 2;
  localparam int MDIO_BURST_W    = 7;

endpackage

// File: rtl/mdio_clock_gen_if.sv
// Control and strobe bundle between the MDIO shift FSM (master) and the MDC generator (slave).
// The burst ports exist only when MDIO_CLOCK_BURST_EN is defined.
interface mdio_clock_gen_if #(
  parameter int DIV_WIDTH = 8
);

  logic                 enable;
  logic [DIV_WIDTH-1:0] half_period;
  logic                 half_period_load;
  logic                 mdc;
  logic                 mdc_rise_en;
  logic                 mdc_fall_en;
  logic                 active;
`ifdef MDIO_CLOCK_BURST_EN
  logic [mdio_pkg::MDIO_BURST_W-1:0] burst_len;
  logic                              burst_start;
  logic                              burst_done;

  modport master (
    output enable, half_period, half_period_load, burst_len, burst_start,
    input  mdc, mdc_rise_en, mdc_fall_en, active, burst_done
  );
  modport slave (
    input  enable, half_period, half_period_load, burst_len, burst_start,
    output mdc, mdc_rise_en, mdc_fall_en, active, burst_done
  );
`else
  modport master (
    output enable, half_period, half_period_load,
    input  mdc, mdc_rise_en, mdc_fall_en, active
  );
  modport slave (
    input  enable, half_period, half_period_load,
    output mdc, mdc_rise_en, mdc_fall_en, active
  );
`endif

endinterface

// File: rtl/mdio_clock_gen.sv
// Programmable MDC generator: registered MDC plus one-cycle rise/fall strobes in the clk domain.
// Define MDIO_CLOCK_BURST_EN to add fixed-length burst mode (burst_len/burst_start/burst_done).
module mdio_clock_gen
  import mdio_pkg::*;
#(
  parameter int DIV_WIDTH           = 8,
  parameter int DEFAULT_HALF_PERIOD = 50
) (
  input  logic             clk,
  input  logic             reset,
  mdio_clock_gen_if.slave  bus
);

  localparam logic [DIV_WIDTH-1:0] HP_RESET = DIV_WIDTH'(DEFAULT_HALF_PERIOD);
  localparam logic [DIV_WIDTH-1:0] HP_MIN   = DIV_WIDTH'(MIN_HALF_PERIOD);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1);

  mdio_clk_state_t      state_q, state_d;
  logic [DIV_WIDTH-1:0] counter_q, counter_d;
  logic [DIV_WIDTH-1:0] hp_cur_q, hp_cur_d;
  logic [DIV_WIDTH-1:0] hp_pend_q, hp_pend_d;
  logic [DIV_WIDTH-1:0] hp_load_val;
  logic                 mdc_q, mdc_d;
  logic                 run;
  logic                 at_boundary;
  logic                 rise_en;
  logic                 fall_en;

  assign hp_load_val = (bus.half_period < HP_MIN) ? HP_MIN : bus.half_period;

`ifdef MDIO_CLOCK_BURST_EN
  logic [MDIO_BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                    burst_mode_q, burst_mode_d;
  logic                    burst_done;

  // A running burst keeps the clock going regardless of enable.
  assign run = burst_mode_q | bus.enable;
`else
  assign run = bus.enable;
`endif

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    mdc_d       = mdc_q;
    rise_en     = 1'b0;
    fall_en     = 1'b0;
    at_boundary = 1'b0;
`ifdef MDIO_CLOCK_BURST_EN
    burst_cnt_d  = burst_cnt_q;
    burst_mode_d = burst_mode_q;
    burst_done   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        mdc_d     = 1'b0;
        counter_d = CNT_ONE;
`ifdef MDIO_CLOCK_BURST_EN
        if (bus.burst_start) begin
          burst_cnt_d  = (bus.burst_len == '0) ? MDIO_BURST_W'(1) : bus.burst_len;
          burst_mode_d = 1'b1;
          state_d      = LOW;
        end else
`endif
        if (bus.enable) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (!run) begin
          state_d   = IDLE;
          counter_d = CNT_ONE;
        end else if (counter_q == hp_cur_q) begin
          rise_en     = 1'b1;
          at_boundary = 1'b1;
          counter_d   = CNT_ONE;
          mdc_d       = 1'b1;
          state_d     = HIGH;
        end else begin
          counter_d = counter_q + CNT_ONE;
        end
      end
      HIGH: begin
        // The high phase always runs to completion so MDC never produces a runt pulse.
        if (counter_q == hp_cur_q) begin
          fall_en     = 1'b1;
          at_boundary = 1'b1;
          counter_d   = CNT_ONE;
          mdc_d       = 1'b0;
`ifdef MDIO_CLOCK_BURST_EN
          if (burst_mode_q) begin
            burst_cnt_d = burst_cnt_q - MDIO_BURST_W'(1);
            if (burst_cnt_q == MDIO_BURST_W'(1)) begin
              burst_done   = 1'b1;
              burst_mode_d = 1'b0;
              state_d      = IDLE;
            end else begin
              state_d = LOW;
            end
          end else
`endif
          state_d = bus.enable ? LOW : IDLE;
        end else begin
          counter_d = counter_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = CNT_ONE;
        mdc_d     = 1'b0;
      end
    endcase

    // A load coinciding with a boundary is forwarded straight into the next half-period.
    hp_pend_d = bus.half_period_load ? hp_load_val : hp_pend_q;
    hp_cur_d  = ((state_q == IDLE) || at_boundary) ? hp_pend_d : hp_cur_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= CNT_ONE;
      hp_cur_q  <= HP_RESET;
      hp_pend_q <= HP_RESET;
      mdc_q     <= 1'b0;
`ifdef MDIO_CLOCK_BURST_EN
      burst_cnt_q  <= '0;
      burst_mode_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      hp_cur_q  <= hp_cur_d;
      hp_pend_q <= hp_pend_d;
      mdc_q     <= mdc_d;
`ifdef MDIO_CLOCK_BURST_EN
      burst_cnt_q  <= burst_cnt_d;
      burst_mode_q <= burst_mode_d;
`endif
    end
  end

  // Strobes are suppressed during reset so an aborted period emits nothing.
  assign bus.mdc         = mdc_q;
  assign bus.mdc_rise_en = rise_en & ~reset;
  assign bus.mdc_fall_en = fall_en & ~reset;
  assign bus.active      = (state_q != IDLE);
`ifdef MDIO_CLOCK_BURST_EN
  assign bus.burst_done  = burst_done & ~reset;
`endif

endmodule

// File: tb/tb_mdio_clock_gen.sv
// Directed bench for mdio_clock_gen: vector table of half-period loads plus hand sequences
// for mid-run loads, stop/reset corners and (with MDIO_CLOCK_BURST_EN) burst mode.
module tb_mdio_clock_gen;

  localparam int LIMIT = 600;

  typedef struct {
    logic [7:0] hp_in;
    int         exp_hp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;
  int   stray = 0;

  mdio_clock_gen_if #(.DIV_WIDTH(8)) bus ();

  mdio_clock_gen #(
    .DIV_WIDTH(8),
    .DEFAULT_HALF_PERIOD(50)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count clk edges until the wanted strobe is seen at a negedge; -1 on timeout.
  task automatic wait_strobe(input bit want_rise, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (bus.mdc_rise_en && bus.mdc_fall_en) stray++;
      else if (want_rise ? bus.mdc_rise_en : bus.mdc_fall_en) begin
        n = k;
        break;
      end else if (bus.mdc_rise_en || bus.mdc_fall_en) stray++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.half_period_load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_hp(input logic [7:0] v);
    bus.half_period = v;
    bus.half_period_load = 1'b1;
    tick();
    bus.half_period_load = 1'b0;
  endtask

  vec_t vecs[6];
  int n;

  initial begin
    vecs[0] = '{8'd5,   5};
    vecs[1] = '{8'd0,   2};
    vecs[2] = '{8'd1,   2};
    vecs[3] = '{8'd2,   2};
    vecs[4] = '{8'd3,   3};
    vecs[5] = '{8'd200, 200};

    bus.enable = 1'b0;
    bus.half_period = 8'd0;
    bus.half_period_load = 1'b0;
`ifdef MDIO_CLOCK_BURST_EN
    bus.burst_len = 7'd0;
    bus.burst_start = 1'b0;
`endif

    // Reset state and default half-period of 50
    do_reset();
    check("reset_mdc", int'(bus.mdc), 0);
    check("reset_rise", int'(bus.mdc_rise_en), 0);
    check("reset_fall", int'(bus.mdc_fall_en), 0);
    check("reset_active", int'(bus.active), 0);
    bus.enable = 1'b1;
    wait_strobe(1'b1, LIMIT, n); check("default_first_rise", n, 50);
    check("default_active", int'(bus.active), 1);
    wait_strobe(1'b0, LIMIT, n); check("default_rise_to_fall", n, 50);
    wait_strobe(1'b1, LIMIT, n); check("default_fall_to_rise", n, 50);
    $display("default run: half-period 50 measured %0d", n);

    // Table: load in IDLE, then run two half-periods and stop mid-HIGH
    for (int i = 0; i < 6; i++) begin
      do_reset();
      load_hp(vecs[i].hp_in);
      bus.enable = 1'b1;
      wait_strobe(1'b1, LIMIT, n); check("vec_first_rise", n, vecs[i].exp_hp);
      check("vec_mdc_low_at_rise", int'(bus.mdc), 0);
      wait_strobe(1'b0, LIMIT, n); check("vec_rise_to_fall", n, vecs[i].exp_hp);
      check("vec_mdc_high_at_fall", int'(bus.mdc), 1);
      wait_strobe(1'b1, LIMIT, n); check("vec_fall_to_rise", n, vecs[i].exp_hp);
      tick();
      check("vec_rise_one_cycle", int'(bus.mdc_rise_en), 0);
      check("vec_mdc_high", int'(bus.mdc), 1);
      bus.enable = 1'b0;
      wait_strobe(1'b0, LIMIT, n); check("vec_fall_after_disable", n, vecs[i].exp_hp - 1);
      tick();
      check("vec_idle_active", int'(bus.active), 0);
      check("vec_idle_mdc", int'(bus.mdc), 0);
      $display("vector %0d: hp_in=%0d expected half-period %0d", i, vecs[i].hp_in, vecs[i].exp_hp);
    end

    // Load hp=3 during the first LOW of an hp=10 run
    do_reset();
    load_hp(8'd10);
    bus.enable = 1'b1;
    tick(); tick(); tick();
    load_hp(8'd3);
    wait_strobe(1'b1, LIMIT, n); check("midload_first_rise", n, 6);
    wait_strobe(1'b0, LIMIT, n); check("midload_high", n, 3);
    wait_strobe(1'b1, LIMIT, n); check("midload_low", n, 3);
    wait_strobe(1'b0, LIMIT, n); check("midload_high2", n, 3);
    $display("mid-LOW load: later half-periods measured %0d", n);

    // Drop enable mid-LOW: idle next cycle, no strobe
    tick();
    bus.enable = 1'b0;
    check("stoplow_no_rise", int'(bus.mdc_rise_en), 0);
    check("stoplow_no_fall", int'(bus.mdc_fall_en), 0);
    tick();
    check("stoplow_active", int'(bus.active), 0);
    check("stoplow_mdc", int'(bus.mdc), 0);
    wait_strobe(1'b1, 20, n); check("stoplow_idle_quiet", n, -1);
    $display("mid-LOW stop: active=%0d mdc=%0d", bus.active, bus.mdc);

    // Reset mid-HIGH, then hp must be back at 50
    do_reset();
    load_hp(8'd4);
    bus.enable = 1'b1;
    wait_strobe(1'b1, LIMIT, n); check("rsthigh_rise", n, 4);
    tick(); tick();
    reset = 1'b1;
    bus.enable = 1'b0;
    check("rsthigh_pre_rise", int'(bus.mdc_rise_en), 0);
    check("rsthigh_pre_fall", int'(bus.mdc_fall_en), 0);
    tick();
    check("rsthigh_mdc", int'(bus.mdc), 0);
    check("rsthigh_active", int'(bus.active), 0);
    check("rsthigh_rise_en", int'(bus.mdc_rise_en), 0);
    check("rsthigh_fall_en", int'(bus.mdc_fall_en), 0);
    reset = 1'b0;
    bus.enable = 1'b1;
    wait_strobe(1'b1, LIMIT, n); check("rsthigh_hp_restored", n, 50);
    $display("reset mid-HIGH: half-period after reset %0d", n);

`ifdef MDIO_CLOCK_BURST_EN
    begin
      int rises, falls, dones, done_on_fall, falls_at_done;
      rises = 0; falls = 0; dones = 0; done_on_fall = 0; falls_at_done = -1;
      do_reset();
      load_hp(8'd2);
      bus.burst_len = 7'd32;
      bus.burst_start = 1'b1;
      tick();
      bus.burst_start = 1'b0;
      check("burst_active", int'(bus.active), 1);
      for (int k = 1; k <= 300; k++) begin
        tick();
        if (bus.mdc_rise_en) rises++;
        if (bus.mdc_fall_en) falls++;
        if (bus.burst_done) begin
          dones++;
          falls_at_done = falls;
          if (bus.mdc_fall_en) done_on_fall++;
        end
        if (k == 20) bus.burst_start = 1'b1;
        if (k == 21) bus.burst_start = 1'b0;
      end
      check("burst_rises", rises, 32);
      check("burst_falls", falls, 32);
      check("burst_done_count", dones, 1);
      check("burst_done_on_fall", done_on_fall, 1);
      check("burst_done_at_32nd", falls_at_done, 32);
      check("burst_end_active", int'(bus.active), 0);
      $display("burst: rises=%0d falls=%0d done=%0d", rises, falls, dones);
    end
`endif

    check("stray_strobes", stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
